// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver delivering host command bytes on a valid/ready stream.
// Includes a 2-FF synchroniser, false-start rejection, stop-bit check and overrun flag.
module uart_rx_stream #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF_DELAY = DELAY_FRAMES / 2;
    localparam int CW = $clog2(DELAY_FRAMES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(HALF_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;
    logic          done;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        done    = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A same-cycle consume frees the holding register for the new byte
        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Randomised bench for uart_rx_stream against a frame-level timing model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_stream;

    localparam int DF = 16;
    localparam int DONE_OFS = 2 + DF / 2 + 9 * DF + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_stream #(.DELAY_FRAMES(DF)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    int total = 0;
    int bad = 0;
    int tnow = 0;

    logic line = 1'b1;
    logic rdy_set = 1'b0;
    logic rst_set = 1'b1;
    bit   rnd_rdy = 1'b0;
    logic rdy_prev = 1'b0;
    logic rst_prev = 1'b1;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    bit         pend = 1'b0;
    int         pend_tick = 0;
    logic [7:0] pend_byte = 8'h00;
    bit         pend_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s: got %0h want %0h (tick %0d)",
                         tag, got, exp, tnow);
        end
    endtask

    task automatic tick();
        logic e_fe;
        logic e_ov;
        logic loaded;
        @(negedge clk);
        tnow++;
        e_fe = 1'b0;
        e_ov = 1'b0;
        loaded = 1'b0;
        if (rst_prev) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            pend    = 1'b0;
        end else begin
            if (pend && tnow == pend_tick) begin
                pend = 1'b0;
                if (!pend_ok) e_fe = 1'b1;
                else if (!m_valid || rdy_prev) begin
                    m_data = pend_byte;
                    loaded = 1'b1;
                end else e_ov = 1'b1;
            end
            if (loaded) m_valid = 1'b1;
            else if (m_valid && rdy_prev) m_valid = 1'b0;
        end
        chk("rx_valid", rx_valid, m_valid);
        chk("rx_data", rx_data, m_data);
        chk("frame_err", frame_err, e_fe);
        chk("overrun", overrun, e_ov);
        uart_rx  = line;
        rx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
        rst      = rst_set;
        rdy_prev = rx_ready;
        rst_prev = rst;
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) tick();
    endtask

    task automatic glitch(input int n);
        line = 1'b0;
        repeat (n) tick();
        idle(24);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok,
                              input int hold, input int pulse_off,
                              input int rst_off);
        int   s;
        logic save;
        s = tnow + 1;
        save = rdy_set;
        pend = 1'b1;
        pend_tick = s + DONE_OFS;
        pend_byte = b;
        pend_ok = ok;
        for (int i = 0; i < 10 * DF; i++) begin
            if (i < DF) line = 1'b0;
            else if (i < 9 * DF) line = b[3'((i - DF) / DF)];
            else line = ok;
            if (i == rst_off) begin
                rst_set = 1'b1;
                line = 1'b1;
                tick();
                rst_set = 1'b0;
                rdy_set = save;
                return;
            end
            rdy_set = (i == pulse_off) ? 1'b1 : save;
            tick();
        end
        rdy_set = save;
        line = 1'b0;
        repeat (hold) tick();
        line = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        int hold;

        rst_set = 1'b1;
        idle(3);
        rst_set = 1'b0;
        idle(6);

        rdy_set = 1'b1;
        send_frame(8'h55, 1, 0, -1, -1);
        idle(20);

        glitch(4);
        send_frame(8'hA3, 1, 0, -1, -1);
        idle(20);

        send_frame(8'h0F, 0, 40, -1, -1);
        idle(10);
        send_frame(8'h81, 1, 0, -1, -1);
        idle(20);

        rdy_set = 1'b0;
        send_frame(8'h12, 1, 0, -1, -1);
        send_frame(8'h34, 1, 0, -1, -1);
        idle(5);
        rdy_set = 1'b1;
        idle(1);
        rdy_set = 1'b0;
        idle(5);

        send_frame(8'h11, 1, 0, -1, -1);
        send_frame(8'h22, 1, 0, DONE_OFS - 1, -1);
        idle(4);
        rdy_set = 1'b1;
        idle(4);

        send_frame(8'hB7, 1, 0, -1, 2 + DF / 2 + 3 * DF + 1);
        idle(20);
        send_frame(8'hC6, 1, 0, -1, -1);
        idle(20);

        rnd_rdy = 1'b1;
        repeat (25) begin
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 6));
            b = 8'($urandom);
            ok = ($urandom_range(0, 6) != 0);
            hold = ok ? 0 : $urandom_range(0, 30);
            send_frame(b, ok, hold, -1, -1);
            idle(ok ? $urandom_range(0, 12) : $urandom_range(4, 12));
        end
        rnd_rdy = 1'b0;
        rdy_set = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
